// File: rtl/ah_snoop_dedup_enqueue.sv
// Snoop-deduplicating enqueue stage in front of a snoopable FIFO.
// Each accepted producer word is snooped against the FIFO contents.
// It is pushed only when it is not already resident in the FIFO.
// Dropped duplicates raise a one-cycle pulse and bump a saturating counter.
module ah_snoop_dedup_enqueue #(
  parameter int DATA_WIDTH = 10,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  dedup_en,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] fifo_wdata,
  output logic                  fifo_wvalid,
  input  logic                  fifo_wready,
  output logic [DATA_WIDTH-1:0] fifo_sdata,
  output logic                  fifo_svalid,
  input  logic                  fifo_smatch,
  output logic                  dup_pulse,
  output logic [CNT_WIDTH-1:0]  drop_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SNOOP = 2'd1,
    PUSH  = 2'd2
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic [DATA_WIDTH-1:0] hold_q;
  logic                  dup_q;
  logic [CNT_WIDTH-1:0]  cnt_q;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    logic [CNT_WIDTH-1:0] r;
    if (&v) r = v;
    else    r = v + CNT_ONE;
    return r;
  endfunction

  // State register; any reset discards the transaction in flight.
  always_ff @(posedge clk) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state: dedup_en only matters on the accept edge out of IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (in_valid) state_d = dedup_en ? SNOOP : PUSH;
      end
      SNOOP: begin
        state_d = fifo_smatch ? IDLE : PUSH;
      end
      PUSH: begin
        if (fifo_wready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Hold register: loaded only on accept, so it stays stable through snoop and a stalled push.
  always_ff @(posedge clk) begin
    if (!rstn)                          hold_q <= '0;
    else if (state_q == IDLE && in_valid) hold_q <= in_data;
  end

  // Duplicate bookkeeping: pulse and count the cycle after a snoop hit.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      dup_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      dup_q <= (state_q == SNOOP) && fifo_smatch;
      if ((state_q == SNOOP) && fifo_smatch) cnt_q <= sat_inc(cnt_q);
    end
  end

  // Output decode: snoop and write requests are tied to their own states, so never overlap.
  always_comb begin
    in_ready    = 1'b0;
    fifo_svalid = 1'b0;
    fifo_wvalid = 1'b0;
    case (state_q)
      IDLE:    in_ready    = 1'b1;
      SNOOP:   fifo_svalid = 1'b1;
      PUSH:    fifo_wvalid = 1'b1;
      default: in_ready    = 1'b0;
    endcase
  end

  assign fifo_wdata = hold_q;
  assign fifo_sdata = hold_q;
  assign dup_pulse  = dup_q;
  assign drop_count = cnt_q;

endmodule

// File: doc/ah_snoop_dedup_enqueue.md
Name: ah_snoop_dedup_enqueue

Overview:
Upstream enqueue stage for the snoopable FIFO. It accepts one producer word at a time and checks it against the FIFO contents using the FIFO's snoop port (sdata/svalid -> smatch). It pushes the word into the FIFO write port only when the word is not already resident, so no duplicate entries are queued. Dropped duplicates are counted and flagged for the performance/debug block.

Parameters:
DATA_WIDTH, 10, width of producer word, FIFO wdata and snoop data
CNT_WIDTH, 16, width of the saturating duplicate-drop counter

Ports:
clk  input  1  clock; all state updates on rising edge
rstn  input  1  reset, synchronous, active-low
dedup_en  input  1  1 = snoop and drop duplicates; 0 = pass-through push
in_data  input  DATA_WIDTH  producer word
in_valid  input  1  producer word valid
in_ready  output  1  stage can accept a producer word
fifo_wdata  output  DATA_WIDTH  word to FIFO write port
fifo_wvalid  output  1  FIFO write request
fifo_wready  input  1  FIFO has space
fifo_sdata  output  DATA_WIDTH  snoop compare value
fifo_svalid  output  1  snoop request
fifo_smatch  input  1  combinational: fifo_sdata is present in FIFO (same cycle)
dup_pulse  output  1  one-cycle pulse when a duplicate is dropped
drop_count  output  CNT_WIDTH  saturating count of dropped duplicates

Behaviour:
- Reset: synchronous on rising clk while rstn=0. State->IDLE, hold register cleared to 0, drop_count=0. Outputs during and after reset: in_ready=1, fifo_wvalid=0, fifo_svalid=0, dup_pulse=0, fifo_wdata=fifo_sdata=0.
- Single-entry hold register hold_q. fifo_wdata and fifo_sdata are both driven from hold_q at all times.
- FSM states: IDLE, SNOOP, PUSH.
- IDLE: in_ready=1. On in_valid=1, capture in_data into hold_q. Go to SNOOP if dedup_en=1, else go to PUSH. Without in_valid, stay in IDLE.
- SNOOP: in_ready=0, fifo_svalid=1 for exactly one cycle. fifo_smatch is sampled at the end of this cycle.
  - smatch=1: drop the word, dup_pulse=1 in the following cycle, drop_count += 1 (holds at all-ones), go to IDLE.
  - smatch=0: go to PUSH.
- PUSH: in_ready=0, fifo_wvalid=1. hold_q is stable while wvalid=1 and wready=0. On wready=1 the word is written; go to IDLE. wvalid deasserts the next cycle. wvalid is never withdrawn before acceptance.
- dedup_en is sampled only at the IDLE accept edge. Changing it mid-transaction does not affect the word already held.
- Latency, no stall: accept at edge N, snoop in cycle N+1, wvalid in cycle N+2, next in_ready in cycle N+3.
  - Peak throughput is 1 word per 3 cycles with dedup, 1 per 2 cycles with pass-through.
  - A dropped duplicate occupies 2 cycles.
- Ordering: a pushed word is resident in the FIFO by the time the next word is snooped, so back-to-back identical inputs yield exactly one push.
- FIFO full (wready=0): the stage holds in PUSH indefinitely and in_ready stays 0 (backpressure propagates upstream).
- fifo_svalid is never asserted outside SNOOP. fifo_wvalid is never asserted outside PUSH. The two are never both 1 in one cycle.
- Reset mid-operation (any state): the held word is discarded, not pushed. Outputs return to reset values on the reset edge.
- Counter saturates at 2^CNT_WIDTH-1 and does not wrap. It is cleared only by reset.

Test Plan:
- Reset then idle: rstn=0 for 2 cycles -> in_ready=1, wvalid=0, svalid=0, drop_count=0; all held while in_valid=0.
- Unique push: dedup_en=1, in_data=0x155, smatch=0, wready=1 -> svalid=1 at N+1 with sdata=0x155; wvalid=1 at N+2 with wdata=0x155; in_ready=1 at N+3; drop_count=0.
- Duplicate drop: dedup_en=1, in_data=0x0AA, smatch=1 in snoop cycle -> no wvalid, dup_pulse=1 for one cycle, drop_count=1, in_ready=1 two cycles after accept.
- Backpressure: unique word 0x3FF, wready=0 for 5 cycles then 1 -> wvalid high 6 cycles with wdata stable at 0x3FF; in_ready=0 throughout; single write.
- Pass-through: dedup_en=0, words 0x001, 0x001 -> svalid never asserted; two pushes of 0x001 at 2-cycle spacing; drop_count=0.
- Reset mid-PUSH plus saturation: word 0x123 held with wready=0, assert rstn=0 -> wvalid=0 next cycle, no write after release. Separately, CNT_WIDTH=2 with 5 duplicate drops -> drop_count=3.
